// File: rtl/join_fork_sched_if.sv
// Handshake bundle for the join/fork token scheduler.
//   en      : fire enable (master -> slave)
//   i_tok   : token offer per place {z,y,x,w} (master -> slave)
//   tok_ack : place can take a token this cycle (slave -> master)
//   vld     : output slot holds a fired result {d,c,b,a} (slave -> master)
//   i_rdy   : consumer ready per output slot (master -> slave)
//   fire    : one-hot strobe of the transition fired at the last edge (slave -> master)
//   cnt     : packed place counters {z,y,x,w} (slave -> master)
//   busy    : any token held or any slot valid (slave -> master)
interface join_fork_sched_if #(
   parameter int unsigned CNT_W = 2
);
   logic               en;
   logic [3:0]         i_tok;
   logic [3:0]         tok_ack;
   logic [3:0]         vld;
   logic [3:0]         i_rdy;
   logic [3:0]         fire;
   logic [4*CNT_W-1:0] cnt;
   logic               busy;

   modport master (
      output en, i_tok, i_rdy,
      input  tok_ack, vld, fire, cnt, busy
   );

   modport slave (
      input  en, i_tok, i_rdy,
      output tok_ack, vld, fire, cnt, busy
   );
endinterface

// File: rtl/join_fork_sched.sv
// Token scheduler for a four-place / four-transition join-fork net.
// Places w,x,y,z; transition a needs {w}, b {w,x}, c {w,x,y}, d {w,x,y,z}.
// Counts tokens per place, round-robin arbitrates the transitions (all share w,
// so at most one grant per cycle), consumes tokens on fire and holds each result
// in a valid/ready slot until the consumer takes it.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : join_fork_sched_if slave modport (en, i_tok, tok_ack, vld, i_rdy, fire, cnt, busy)
module join_fork_sched #(
   parameter int unsigned CNT_W = 2
) (
   input logic               clk,
   input logic               rst,
   join_fork_sched_if.slave  bus
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   // Places required by each transition: a prefix of {w,x,y,z}.
   function automatic logic [3:0] need(input logic [1:0] t);
      logic [3:0] m;
      case (t)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       vld_q, vld_d;
   logic [3:0]       fire_q, fire_d;
   logic [1:0]       rr_q, rr_d;

   logic [3:0] nz;
   logic [3:0] ack;
   logic [3:0] enab;
   logic [3:0] accept;
   logic [3:0] consume;
   logic       gnt_vld;
   logic [1:0] gnt;
   logic [1:0] idx;

   always_comb begin
      nz      = '0;
      ack     = '0;
      enab    = '0;
      gnt_vld = 1'b0;
      gnt     = rr_q;
      idx     = rr_q;

      for (int k = 0; k < 4; k++) begin
         nz[k]  = (cnt_q[k] != '0);
         // Registered count only: a full place being drained still refuses.
         ack[k] = (cnt_q[k] != CntMax);
      end

      // Slot is free if empty or being drained this cycle.
      for (int t = 0; t < 4; t++) begin
         enab[t] = bus.en & (~vld_q[t] | bus.i_rdy[t]) & (&(nz | ~need(2'(t))));
      end

      // Round-robin search starting at rr, ascending modulo 4.
      for (int off = 0; off < 4; off++) begin
         idx = rr_q + 2'(off);
         if (!gnt_vld && enab[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
         end
      end
   end

   always_comb begin
      accept  = bus.i_tok & ack;
      consume = gnt_vld ? need(gnt) : 4'b0000;
      fire_d  = gnt_vld ? (4'b0001 << gnt) : 4'b0000;
      // Grant sets the slot (covers drain+refill); otherwise drain on ready.
      vld_d   = fire_d | (vld_q & ~bus.i_rdy);
      rr_d    = gnt_vld ? gnt + 2'd1 : rr_q;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = cnt_q[k];
         case ({accept[k], consume[k]})
            2'b10:   cnt_d[k] = cnt_q[k] + CntOne;
            2'b01:   cnt_d[k] = cnt_q[k] - CntOne;
            default: cnt_d[k] = cnt_q[k];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
         vld_q  <= '0;
         fire_q <= '0;
         rr_q   <= '0;
      end else begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
         vld_q  <= vld_d;
         fire_q <= fire_d;
         rr_q   <= rr_d;
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_cnt
      assign bus.cnt[k*CNT_W +: CNT_W] = cnt_q[k];
   end

   assign bus.tok_ack = ack;
   assign bus.vld     = vld_q;
   assign bus.fire    = fire_q;
   assign bus.busy    = (|nz) | (|vld_q);

endmodule

// File: tb/tb_join_fork_sched.sv
// Self-checking bench for join_fork_sched. Expected fire strobes are queued when
// stimulus is driven and popped by a monitor whenever the DUT pulses fire.
module tb_join_fork_sched;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   join_fork_sched_if #(.CNT_W(2)) bus ();

   join_fork_sched #(.CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] sb[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #3 rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: every fire pulse must match the oldest queued expectation.
   always begin
      @(posedge clk);
      #2;
      if (!rst && bus.fire !== 4'b0000) begin
         if (sb.size() > 0) check_eq("fire_sb", 32'(bus.fire), 32'(sb.pop_front()));
         else               check_eq("fire_unexpected", 32'(bus.fire), 32'h0);
      end
   end

   initial begin
      rst       = 1'b1;
      bus.en    = 1'b0;
      bus.i_tok = 4'b0000;
      bus.i_rdy = 4'b0000;
      tick(2);
      rst = 1'b0;
      check_eq("rst_tok_ack", 32'(bus.tok_ack), 32'hf);
      check_eq("rst_cnt", 32'(bus.cnt), 32'h0);
      check_eq("rst_busy", 32'(bus.busy), 32'h0);

      // Single token latency.
      bus.en    = 1'b1;
      bus.i_rdy = 4'b1111;
      bus.i_tok = 4'b0001;
      sb.push_back(4'b0001);
      tick(1);
      bus.i_tok = 4'b0000;
      check_eq("lat_cnt_c1", 32'(bus.cnt[1:0]), 32'd1);
      check_eq("lat_fire_c1", 32'(bus.fire), 32'h0);
      tick(1);
      check_eq("lat_fire_c2", 32'(bus.fire), 32'b0001);
      check_eq("lat_vld_c2", 32'(bus.vld), 32'b0001);
      check_eq("lat_cnt_c2", 32'(bus.cnt[1:0]), 32'd0);
      tick(1);
      check_eq("lat_vld_c3", 32'(bus.vld), 32'h0);
      check_eq("lat_busy_c3", 32'(bus.busy), 32'h0);

      // Reset mid-stream with w=2 and slot b held (rr is 1, so b wins).
      bus.en    = 1'b0;
      bus.i_rdy = 4'b0000;
      bus.i_tok = 4'b0011;
      tick(1);
      bus.i_tok = 4'b0001;
      tick(2);
      bus.i_tok = 4'b0000;
      check_eq("mid_preload", 32'(bus.cnt), 32'h07);
      bus.en = 1'b1;
      sb.push_back(4'b0010);
      tick(1);
      bus.en = 1'b0;
      check_eq("mid_vld", 32'(bus.vld), 32'b0010);
      check_eq("mid_cnt", 32'(bus.cnt), 32'h02);
      #3 rst = 1'b1;
      #1;
      check_eq("mid_rst_cnt", 32'(bus.cnt), 32'h0);
      check_eq("mid_rst_vld", 32'(bus.vld), 32'h0);
      check_eq("mid_rst_fire", 32'(bus.fire), 32'h0);
      check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
      check_eq("mid_rst_ack", 32'(bus.tok_ack), 32'hf);
      tick(1);
      rst = 1'b0;
      check_eq("mid_rst_rr", 32'(dut.rr_q), 32'd0);

      // Round-robin on shared w: a, b, a.
      bus.i_rdy = 4'b1111;
      bus.i_tok = 4'b1111;
      tick(1);
      bus.i_tok = 4'b0001;
      tick(2);
      bus.i_tok = 4'b0000;
      check_eq("rr_preload", 32'(bus.cnt), 32'h57);
      sb.push_back(4'b0001);
      sb.push_back(4'b0010);
      sb.push_back(4'b0001);
      bus.en = 1'b1;
      tick(1);
      check_eq("rr_fire0", 32'(bus.fire), 32'b0001);
      tick(1);
      check_eq("rr_fire1", 32'(bus.fire), 32'b0010);
      tick(1);
      check_eq("rr_fire2", 32'(bus.fire), 32'b0001);
      tick(1);
      check_eq("rr_fire3", 32'(bus.fire), 32'h0);
      check_eq("rr_cnt", 32'(bus.cnt), 32'h50);
      check_eq("rr_ptr", 32'(dut.rr_q), 32'd1);
      bus.en = 1'b0;
      do_reset();

      // Full place.
      bus.i_tok = 4'b0001;
      check_eq("full_ack_c0", 32'(bus.tok_ack[0]), 32'd1);
      tick(3);
      check_eq("full_ack_c3", 32'(bus.tok_ack[0]), 32'd0);
      check_eq("full_cnt_c3", 32'(bus.cnt[1:0]), 32'd3);
      tick(1);
      bus.i_tok = 4'b0000;
      check_eq("full_cnt_c4", 32'(bus.cnt[1:0]), 32'd3);
      do_reset();

      // Backpressure on slot a, then drain+refill.
      bus.i_tok = 4'b0001;
      tick(2);
      bus.i_tok = 4'b0000;
      check_eq("bp_preload", 32'(bus.cnt[1:0]), 32'd2);
      bus.i_rdy = 4'b1110;
      bus.en    = 1'b1;
      sb.push_back(4'b0001);
      tick(1);
      check_eq("bp_fire0", 32'(bus.fire), 32'b0001);
      check_eq("bp_cnt0", 32'(bus.cnt[1:0]), 32'd1);
      tick(2);
      check_eq("bp_hold_fire", 32'(bus.fire), 32'h0);
      check_eq("bp_hold_vld", 32'(bus.vld[0]), 32'd1);
      check_eq("bp_hold_cnt", 32'(bus.cnt[1:0]), 32'd1);
      bus.i_rdy = 4'b1111;
      sb.push_back(4'b0001);
      tick(1);
      check_eq("bp_refill_fire", 32'(bus.fire), 32'b0001);
      check_eq("bp_refill_vld", 32'(bus.vld[0]), 32'd1);
      check_eq("bp_refill_cnt", 32'(bus.cnt[1:0]), 32'd0);
      tick(1);
      check_eq("bp_drain_vld", 32'(bus.vld), 32'h0);
      check_eq("bp_drain_busy", 32'(bus.busy), 32'h0);
      bus.en = 1'b0;
      do_reset();

      // Full join d: walk rr to 3 via a, b, c with a/b slots held.
      bus.i_tok = 4'b0011;
      tick(1);
      bus.i_tok = 4'b0001;
      tick(1);
      bus.i_tok = 4'b0000;
      check_eq("join_pre1", 32'(bus.cnt), 32'h06);
      bus.i_rdy = 4'b1100;
      bus.en    = 1'b1;
      sb.push_back(4'b0001);
      sb.push_back(4'b0010);
      tick(1);
      check_eq("join_fire_a", 32'(bus.fire), 32'b0001);
      tick(1);
      bus.en = 1'b0;
      check_eq("join_fire_b", 32'(bus.fire), 32'b0010);
      bus.i_tok = 4'b1111;
      tick(1);
      bus.i_tok = 4'b0111;
      tick(1);
      bus.i_tok = 4'b0000;
      check_eq("join_pre2", 32'(bus.cnt), 32'h6a);
      check_eq("join_rr2", 32'(dut.rr_q), 32'd2);
      bus.en = 1'b1;
      sb.push_back(4'b0100);
      sb.push_back(4'b1000);
      tick(1);
      check_eq("join_fire_c", 32'(bus.fire), 32'b0100);
      check_eq("join_cnt_c", 32'(bus.cnt), 32'h55);
      tick(1);
      bus.en = 1'b0;
      check_eq("join_fire_d", 32'(bus.fire), 32'b1000);
      check_eq("join_cnt_d", 32'(bus.cnt), 32'h00);
      check_eq("join_vld_d", 32'(bus.vld), 32'b1011);
      check_eq("join_busy_d", 32'(bus.busy), 32'd1);
      bus.i_rdy = 4'b1111;
      tick(1);
      check_eq("join_drain_vld", 32'(bus.vld), 32'h0);
      check_eq("join_drain_busy", 32'(bus.busy), 32'h0);

      tick(1);
      check_eq("sb_left", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
